// File: rtl/cdc_hsk_pkg.sv
// rtl/cdc_hsk_pkg.sv - shared types and limits for the req/ack CDC handshake endpoints
package cdc_hsk_pkg;

  // Receiver handshake states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } hsk_state_e;

  // Legal synchronizer depth range for the request/ack level synchronizers
  localparam int CDC_SYNC_FF_MIN = 2;
  localparam int CDC_SYNC_FF_MAX = 10;

  // Default width of the transferred word
  localparam int CDC_DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/cdc_sync_bit_arstn.sv
// rtl/cdc_sync_bit_arstn.sv - multi-stage single-bit level synchronizer, async active-low reset to 0
(* KEEP_HIERARCHY = "TRUE" *)
module cdc_sync_bit_arstn #(
  parameter int SYNC_FF = 3
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_d,
  output logic o_q
);

  // Flops kept together and untouched so placement keeps the metastability chain tight
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [SYNC_FF-1:0] r_sync;

  // Shift the asynchronous level through the chain; stage 0 is the only one that may go metastable
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_FF-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// rtl/cdc_handshake_rx.sv - destination endpoint of a 4-phase req/ack CDC handshake with valid/ready output
module cdc_handshake_rx
  import cdc_hsk_pkg::*;
#(
  parameter int DATA_WIDTH   = CDC_DATA_WIDTH_DEFAULT,
  parameter int DEST_SYNC_FF = 3
) (
  input  logic                  dest_clk,
  input  logic                  dest_arst_n,
  input  logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  dest_ack,
  output logic                  dest_valid,
  output logic [DATA_WIDTH-1:0] dest_data,
  input  logic                  dest_ready,
  output logic                  dest_err
);

  if ((DEST_SYNC_FF < CDC_SYNC_FF_MIN) || (DEST_SYNC_FF > CDC_SYNC_FF_MAX)) begin : g_bad_sync_ff
    $error("cdc_handshake_rx: DEST_SYNC_FF out of range");
  end

  hsk_state_e            r_state;
  hsk_state_e            w_state_nxt;
  logic                  r_ack;
  logic                  r_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_req_s;
  logic                  w_ack_nxt;
  logic                  w_valid_nxt;
  logic                  w_capture;
  logic                  w_err_set;

  cdc_sync_bit_arstn #(
    .SYNC_FF (DEST_SYNC_FF)
  ) u_req_sync (
    .i_clk    (dest_clk),
    .i_arst_n (dest_arst_n),
    .i_d      (src_req),
    .o_q      (w_req_s)
  );

  // Next-state and output decisions; ready beats a simultaneous request withdrawal
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s) begin
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (dest_ready) begin
          w_valid_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
        end else if (!w_req_s) begin
          w_valid_nxt = 1'b0;
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and handshake flags; ack comes straight from a flop so the source sees a clean level
  always_ff @(posedge dest_clk or negedge dest_arst_n) begin
    if (!dest_arst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_valid <= w_valid_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Capture the source-held bus only when the request is first seen; it is stable by protocol
  always_ff @(posedge dest_clk or negedge dest_arst_n) begin
    if (!dest_arst_n) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= src_data;
    end
  end

  assign dest_ack   = r_ack;
  assign dest_valid = r_valid;
  assign dest_data  = r_data;
  assign dest_err   = r_err;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb/tb_cdc_handshake_rx.sv - self-checking bench for cdc_handshake_rx at sync depths 3, 2 and 10
module tb_cdc_handshake_rx;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  ready;
  logic [31:0] sdata [3];
  wire  [2:0]  w_ack;
  wire  [2:0]  w_valid;
  wire  [2:0]  w_err;
  wire  [31:0] w_data0;
  wire  [7:0]  w_data1;
  wire  [7:0]  w_data2;

  int n_pass  = 0;
  int n_total = 0;

  cdc_handshake_rx #(.DATA_WIDTH(32), .DEST_SYNC_FF(3)) u_dut0 (
    .dest_clk    (clk),
    .dest_arst_n (rst_n),
    .src_req     (req[0]),
    .src_data    (sdata[0]),
    .dest_ack    (w_ack[0]),
    .dest_valid  (w_valid[0]),
    .dest_data   (w_data0),
    .dest_ready  (ready[0]),
    .dest_err    (w_err[0])
  );

  cdc_handshake_rx #(.DATA_WIDTH(8), .DEST_SYNC_FF(2)) u_dut1 (
    .dest_clk    (clk),
    .dest_arst_n (rst_n),
    .src_req     (req[1]),
    .src_data    (sdata[1][7:0]),
    .dest_ack    (w_ack[1]),
    .dest_valid  (w_valid[1]),
    .dest_data   (w_data1),
    .dest_ready  (ready[1]),
    .dest_err    (w_err[1])
  );

  cdc_handshake_rx #(.DATA_WIDTH(8), .DEST_SYNC_FF(10)) u_dut2 (
    .dest_clk    (clk),
    .dest_arst_n (rst_n),
    .src_req     (req[2]),
    .src_data    (sdata[2][7:0]),
    .dest_ack    (w_ack[2]),
    .dest_valid  (w_valid[2]),
    .dest_data   (w_data2),
    .dest_ready  (ready[2]),
    .dest_err    (w_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dout(input int idx);
    case (idx)
      0:       return w_data0;
      1:       return {24'h0, w_data1};
      default: return {24'h0, w_data2};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Source model: one word per full 4-phase round trip, random back-pressure and release gap.
  // Expected capture and release latencies are sync depth + 1 ticks from the input change.
  task automatic run_sweep(input int idx, input int n_words, input int nsync);
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] word;
    int          lat;
    int          hold;
    int          gap;
    int          dup;
    int          nbad;
    bit          ok;
    for (int w = 0; w < n_words; w++) begin
      word = 32'($urandom_range(0, 255));
      sdata[idx] = word;
      req[idx]   = 1'b1;
      exp_q.push_back(word);
      lat = 0;
      while (!w_valid[idx] && lat < 64) begin
        tick();
        lat++;
      end
      chk("sweep_capture_latency", 32'(lat), 32'(nsync + 1));
      hold = $urandom_range(0, 3);
      ok = 1'b1;
      repeat (hold) begin
        tick();
        if (!w_valid[idx] || w_ack[idx] || dout(idx) !== word) ok = 1'b0;
      end
      chk("sweep_backpressure_hold", 32'(ok), 32'd1);
      got_q.push_back(dout(idx));
      ready[idx] = 1'b1;
      tick();
      chk("sweep_ack_valid", {30'd0, w_ack[idx], w_valid[idx]}, 32'd2);
      ready[idx] = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      req[idx] = 1'b0;
      lat = 0;
      dup = 0;
      while (w_ack[idx] && lat < 64) begin
        tick();
        lat++;
        if (w_valid[idx]) dup++;
      end
      chk("sweep_release_latency", 32'(lat), 32'(nsync + 1));
      chk("sweep_no_duplicate", 32'(dup), 32'd0);
    end
    chk("sweep_word_count", 32'(got_q.size()), 32'(n_words));
    nbad = 0;
    for (int i = 0; i < n_words && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) nbad++;
    end
    chk("sweep_in_order", 32'(nbad), 32'd0);
    chk("sweep_err_clear", {31'd0, w_err[idx]}, 32'd0);
  endtask

  initial begin
    int nv;
    int nack;
    bit ack_seen;
    rst_n = 1'b1;
    req   = 3'b000;
    ready = 3'b000;
    for (int i = 0; i < 3; i++) sdata[i] = 32'h0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ack",   {31'd0, w_ack[0]},   32'd0);
    chk("reset_valid", {31'd0, w_valid[0]}, 32'd0);
    chk("reset_data",  w_data0,             32'd0);
    chk("reset_err",   {31'd0, w_err[0]},   32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic transfer: req sampled at edge 0
    sdata[0] = 32'hDEADBEEF;
    ready[0] = 1'b1;
    req[0]   = 1'b1;
    repeat (3) tick();
    chk("basic_valid_after_e2", {31'd0, w_valid[0]}, 32'd0);
    tick();
    chk("basic_valid_after_e3", {31'd0, w_valid[0]}, 32'd1);
    chk("basic_data_after_e3",  w_data0,             32'hDEADBEEF);
    tick();
    chk("basic_ack_after_e4",   {31'd0, w_ack[0]},   32'd1);
    chk("basic_valid_after_e4", {31'd0, w_valid[0]}, 32'd0);
    repeat (5) tick();
    req[0] = 1'b0;
    repeat (3) tick();
    chk("basic_ack_after_e12", {31'd0, w_ack[0]}, 32'd1);
    tick();
    chk("basic_ack_after_e13", {31'd0, w_ack[0]}, 32'd0);
    ready[0] = 1'b0;
    repeat (2) tick();

    // Back-pressure for 20 cycles
    sdata[0] = 32'hA5A55A5A;
    req[0]   = 1'b1;
    repeat (4) tick();
    chk("bp_valid_rise", {31'd0, w_valid[0]}, 32'd1);
    sdata[0] = 32'h0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_valid_ack", {30'd0, w_valid[0], w_ack[0]}, 32'd2);
      chk("bp_data",      w_data0,                       32'hA5A55A5A);
    end
    ready[0] = 1'b1;
    tick();
    chk("bp_ack_rise",   {31'd0, w_ack[0]},   32'd1);
    chk("bp_valid_fall", {31'd0, w_valid[0]}, 32'd0);

    // No duplicate while req stays high
    nv = 0;
    nack = 0;
    repeat (50) begin
      tick();
      if (w_valid[0]) nv++;
      if (!w_ack[0]) nack++;
    end
    chk("nodup_valid_cycles", 32'(nv),   32'd0);
    chk("nodup_ack_low",      32'(nack), 32'd0);
    req[0] = 1'b0;
    repeat (4) tick();
    chk("nodup_ack_release", {31'd0, w_ack[0]}, 32'd0);
    ready[0] = 1'b0;
    tick();

    // Protocol error: source withdraws while consumer stalls
    sdata[0] = 32'h11112222;
    req[0]   = 1'b1;
    repeat (4) tick();
    chk("err_valid_rise", {31'd0, w_valid[0]}, 32'd1);
    req[0] = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      tick();
      if (w_ack[0]) ack_seen = 1'b1;
    end
    chk("err_valid_still", {31'd0, w_valid[0]}, 32'd1);
    chk("err_not_yet",     {31'd0, w_err[0]},   32'd0);
    tick();
    chk("err_valid_drop", {31'd0, w_valid[0]}, 32'd0);
    chk("err_flag_set",   {31'd0, w_err[0]},   32'd1);
    repeat (10) begin
      tick();
      if (w_ack[0]) ack_seen = 1'b1;
    end
    chk("err_ack_never",  32'(ack_seen), 32'd0);
    chk("err_data_held",  w_data0,       32'h11112222);
    sdata[0] = 32'h12345678;
    ready[0] = 1'b1;
    req[0]   = 1'b1;
    repeat (4) tick();
    chk("err_next_valid", {31'd0, w_valid[0]}, 32'd1);
    chk("err_next_data",  w_data0,             32'h12345678);
    tick();
    chk("err_next_ack", {31'd0, w_ack[0]}, 32'd1);
    req[0] = 1'b0;
    repeat (4) tick();
    chk("err_next_release", {31'd0, w_ack[0]}, 32'd0);
    chk("err_sticky",       {31'd0, w_err[0]}, 32'd1);
    ready[0] = 1'b0;
    tick();

    // Reset in ACK, asynchronously, then release with req still high
    sdata[0] = 32'hCAFEF00D;
    ready[0] = 1'b1;
    req[0]   = 1'b1;
    repeat (5) tick();
    chk("rst_in_ack", {31'd0, w_ack[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ack",   {31'd0, w_ack[0]},   32'd0);
    chk("rst_async_valid", {31'd0, w_valid[0]}, 32'd0);
    chk("rst_async_data",  w_data0,             32'd0);
    chk("rst_async_err",   {31'd0, w_err[0]},   32'd0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_recap_early", {31'd0, w_valid[0]}, 32'd0);
    tick();
    chk("rst_recap_valid", {31'd0, w_valid[0]}, 32'd1);
    chk("rst_recap_data",  w_data0,             32'hCAFEF00D);
    tick();
    chk("rst_recap_ack", {31'd0, w_ack[0]}, 32'd1);
    req[0]   = 1'b0;
    ready[0] = 1'b0;
    repeat (4) tick();
    chk("rst_recap_release", {31'd0, w_ack[0]}, 32'd0);

    // Parameter sweep with random words
    run_sweep(1, 1000, 2);
    run_sweep(2, 1000, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
